// File: rtl/fifo2axis.sv
// rtl/fifo2axis.sv - drains PKT_LEN-word packets from a synchronous FIFO and replays them as AXI-Stream bursts
module fifo2axis #(
    parameter int DATA_WIDTH = 32,
    parameter int PKT_LEN    = 4
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic [DATA_WIDTH-1:0] fifo_dout,
    input  logic                  fifo_empty,
    output logic                  fifo_rd_en,
    output logic [DATA_WIDTH-1:0] m_axis_tdata,
    output logic                  m_axis_tvalid,
    input  logic                  m_axis_tready,
    output logic                  m_axis_tlast,
    output logic                  busy,
    output logic [15:0]           pkt_count
);

    localparam int IDX_W = $clog2(PKT_LEN);
    localparam int CNT_W = $clog2(PKT_LEN + 1);
    localparam logic [IDX_W-1:0] LAST_IDX  = IDX_W'(PKT_LEN - 1);
    localparam logic [CNT_W-1:0] PKT_LEN_C = CNT_W'(PKT_LEN);

    typedef enum logic [1:0] {IDLE, FETCH, STREAM} state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      issued_q, issued_d;
    logic [IDX_W-1:0]      wr_idx_q, wr_idx_d;
    logic [IDX_W-1:0]      rd_idx_q, rd_idx_d;
    logic                  rd_en_dly_q, rd_en_dly_d;
    logic [15:0]           pkt_count_q, pkt_count_d;
    logic [DATA_WIDTH-1:0] pkt_buf_q [PKT_LEN];
    logic                  handshake;

    assign m_axis_tvalid = (state_q == STREAM);
    assign m_axis_tdata  = m_axis_tvalid ? pkt_buf_q[rd_idx_q] : '0;
    assign m_axis_tlast  = m_axis_tvalid && (rd_idx_q == LAST_IDX);
    assign busy          = (state_q != IDLE);
    assign pkt_count     = pkt_count_q;
    assign handshake     = m_axis_tvalid && m_axis_tready;

    always_comb begin
        state_d     = state_q;
        issued_d    = issued_q;
        wr_idx_d    = wr_idx_q;
        rd_idx_d    = rd_idx_q;
        pkt_count_d = pkt_count_q;
        fifo_rd_en  = 1'b0;

        case (state_q)
            IDLE: begin
                fifo_rd_en = !fifo_empty;
                if (fifo_rd_en) begin
                    issued_d = CNT_W'(1);
                    state_d  = FETCH;
                end
            end
            FETCH: begin
                fifo_rd_en = !fifo_empty && (issued_q < PKT_LEN_C);
                if (fifo_rd_en) begin
                    issued_d = issued_q + CNT_W'(1);
                end
            end
            STREAM: begin
                if (handshake) begin
                    if (rd_idx_q == LAST_IDX) begin
                        pkt_count_d = pkt_count_q + 16'd1;
                        issued_d    = '0;
                        rd_idx_d    = '0;
                        state_d     = IDLE;
                    end else begin
                        rd_idx_d = rd_idx_q + IDX_W'(1);
                    end
                end
            end
            default: state_d = IDLE;
        endcase

        // The word strobed last cycle lands now, even if the FIFO has since gone empty
        if (rd_en_dly_q) begin
            if (wr_idx_q == LAST_IDX) begin
                wr_idx_d = '0;
                if (state_q == FETCH) begin
                    rd_idx_d = '0;
                    state_d  = STREAM;
                end
            end else begin
                wr_idx_d = wr_idx_q + IDX_W'(1);
            end
        end

        if (rst) begin
            fifo_rd_en = 1'b0;
        end
        rd_en_dly_d = fifo_rd_en;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= IDLE;
            issued_q    <= '0;
            wr_idx_q    <= '0;
            rd_idx_q    <= '0;
            rd_en_dly_q <= 1'b0;
            pkt_count_q <= '0;
        end else begin
            state_q     <= state_d;
            issued_q    <= issued_d;
            wr_idx_q    <= wr_idx_d;
            rd_idx_q    <= rd_idx_d;
            rd_en_dly_q <= rd_en_dly_d;
            pkt_count_q <= pkt_count_d;
        end
    end

    always_ff @(posedge clk) begin
        if (rd_en_dly_q) begin
            pkt_buf_q[wr_idx_q] <= fifo_dout;
        end
    end

endmodule

// File: tb/tb_fifo2axis.sv
// tb/tb_fifo2axis.sv - scoreboard bench for fifo2axis with a one-cycle-latency FIFO model
module tb_fifo2axis;

    localparam int DW = 32;
    localparam int PL = 4;

    logic          clk = 1'b0;
    logic          rst;
    logic [DW-1:0] fifo_dout;
    logic          fifo_empty;
    logic          fifo_rd_en;
    logic [DW-1:0] m_axis_tdata;
    logic          m_axis_tvalid;
    logic          m_axis_tready;
    logic          m_axis_tlast;
    logic          busy;
    logic [15:0]   pkt_count;

    fifo2axis #(.DATA_WIDTH(DW), .PKT_LEN(PL)) dut (
        .clk           (clk),
        .rst           (rst),
        .fifo_dout     (fifo_dout),
        .fifo_empty    (fifo_empty),
        .fifo_rd_en    (fifo_rd_en),
        .m_axis_tdata  (m_axis_tdata),
        .m_axis_tvalid (m_axis_tvalid),
        .m_axis_tready (m_axis_tready),
        .m_axis_tlast  (m_axis_tlast),
        .busy          (busy),
        .pkt_count     (pkt_count)
    );

    always #5 clk = ~clk;

    logic [DW-1:0] fmem [0:63];
    int wp = 0;
    int rp = 0;

    assign fifo_empty = (rp == wp);

    always @(posedge clk) begin
        if (fifo_rd_en && (rp != wp)) begin
            fifo_dout <= fmem[rp[5:0]];
            rp        <= rp + 1;
        end
    end

    typedef struct {
        logic [DW-1:0] data;
        logic          last;
    } beat_t;

    beat_t exp_q [$];
    int    pos    = 0;
    int    errors = 0;
    int    checks = 0;
    int    hs_cnt = 0;

    task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
        checks++;
        if (got !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(negedge clk);
    endtask

    task automatic push_word(input logic [DW-1:0] d);
        beat_t b;
        fmem[wp[5:0]] = d;
        wp = wp + 1;
        b.data = d;
        b.last = (pos == PL - 1);
        exp_q.push_back(b);
        pos = (pos + 1) % PL;
    endtask

    task automatic wait_count(input logic [15:0] target, input string tag);
        int n = 0;
        while (pkt_count !== target && n < 200) begin
            tick();
            #1;
            n++;
        end
        check(tag, pkt_count, target);
    endtask

    task automatic wait_valid(input string tag);
        int n = 0;
        #1;
        while (!m_axis_tvalid && n < 50) begin
            tick();
            #1;
            n++;
        end
        check(tag, m_axis_tvalid, 1);
    endtask

    // Beat checker: every accepted beat must match the next word in FIFO order
    always @(negedge clk) begin
        beat_t e;
        #2;
        if (!rst) begin
            check("rd_while_empty", fifo_rd_en & fifo_empty, 0);
            check("rd_in_stream", fifo_rd_en & m_axis_tvalid, 0);
            if (m_axis_tvalid && m_axis_tready) begin
                hs_cnt++;
                if (exp_q.size() == 0) begin
                    check("sb_extra_beat", 1, 0);
                end else begin
                    e = exp_q.pop_front();
                    check("beat_data", m_axis_tdata, e.data);
                    check("beat_last", m_axis_tlast, e.last);
                end
            end
        end
    end

    initial begin
        int hs0;
        rst           = 1'b1;
        m_axis_tready = 1'b1;
        repeat (3) tick();
        #1;
        check("rst_tvalid", m_axis_tvalid, 0);
        check("rst_tlast", m_axis_tlast, 0);
        check("rst_tdata", m_axis_tdata, 0);
        check("rst_busy", busy, 0);
        check("rst_pkt_count", pkt_count, 0);
        check("rst_rd_en", fifo_rd_en, 0);

        tick();
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        #1;
        check("rst_rd_en_nonempty", fifo_rd_en, 0);

        // Steady stream: cycle 0 is the first cycle out of reset with data waiting
        tick();
        rst = 1'b0;
        for (int c = 0; c < 10; c++) begin
            #1;
            check($sformatf("ss_rd_en_c%0d", c), fifo_rd_en, (c < 4));
            check($sformatf("ss_tvalid_c%0d", c), m_axis_tvalid, (c >= 5 && c <= 8));
            check($sformatf("ss_tlast_c%0d", c), m_axis_tlast, (c == 8));
            check($sformatf("ss_busy_c%0d", c), busy, (c >= 1 && c <= 8));
            if (c == 9) check("ss_pkt_count", pkt_count, 1);
            tick();
        end

        // Backpressure on the second beat
        hs0 = hs_cnt;
        push_word(32'h11); push_word(32'h22); push_word(32'h33); push_word(32'h44);
        wait_valid("bp_first_valid");
        tick();
        m_axis_tready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            #1;
            check("bp_hold_valid", m_axis_tvalid, 1);
            check("bp_hold_data", m_axis_tdata, 32'h22);
            check("bp_hold_last", m_axis_tlast, 0);
            tick();
        end
        m_axis_tready = 1'b1;
        wait_count(16'd2, "bp_pkt_count");
        check("bp_handshakes", hs_cnt - hs0, 4);

        // Underrun: two words now, two more after five cycles
        tick();
        hs0 = hs_cnt;
        push_word(32'h55); push_word(32'h66);
        for (int i = 0; i < 5; i++) begin
            #1;
            check("ur_no_valid", m_axis_tvalid, 0);
            tick();
        end
        push_word(32'h77); push_word(32'h88);
        wait_count(16'd3, "ur_pkt_count");
        check("ur_handshakes", hs_cnt - hs0, 4);

        // Back-to-back packets
        tick();
        hs0 = hs_cnt;
        for (int i = 1; i <= 8; i++) push_word(DW'(i));
        wait_count(16'd5, "b2b_pkt_count");
        check("b2b_handshakes", hs_cnt - hs0, 8);

        // Reset after two beats of a packet
        tick();
        push_word(32'hA1); push_word(32'hA2); push_word(32'hA3); push_word(32'hA4);
        wait_valid("mr_first_valid");
        tick();
        tick();
        rst = 1'b1;
        exp_q.delete();
        pos = 0;
        tick();
        #1;
        check("mr_tvalid", m_axis_tvalid, 0);
        check("mr_busy", busy, 0);
        check("mr_pkt_count", pkt_count, 0);
        tick();
        rst = 1'b0;
        hs0 = hs_cnt;
        push_word(32'hB1); push_word(32'hB2); push_word(32'hB3); push_word(32'hB4);
        wait_count(16'd1, "mr_next_pkt");
        check("mr_handshakes", hs_cnt - hs0, 4);

        // Counter wrap from a preset near the top
        tick();
        force dut.pkt_count_q = 16'hFFFE;
        tick();
        release dut.pkt_count_q;
        #1;
        check("wrap_preset", pkt_count, 16'hFFFE);
        for (int i = 0; i < 8; i++) push_word(32'hC0 + DW'(i));
        wait_count(16'hFFFF, "wrap_ffff");
        wait_count(16'h0000, "wrap_zero");

        repeat (3) tick();
        check("sb_drained", exp_q.size(), 0);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected finish");
        $fatal(1, "watchdog");
    end

endmodule
